// File: rtl/sample_recorder.sv
// Captures an 8-bit audio stream into a sample RAM while rec is held; registered read port for playback.
// Optional macro THRESHOLD_TRIG_EN: arm on a rec rising edge and start capture on the first loud sample.
module sample_recorder #(
   parameter int DEPTH     = 4096,
   parameter int ADDR_W    = 12,
   parameter int THRESHOLD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rec,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic [ADDR_W:0]   rec_len,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_REC, ST_DONE} state_t;

`ifdef THRESHOLD_TRIG_EN
   localparam state_t START_ST = ST_ARMED;
`else
   localparam state_t START_ST = ST_REC;
`endif

   localparam logic [ADDR_W:0]   LEN_LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic signed [8:0] THR      = 9'(THRESHOLD);

   state_t              state_q, state_d;
   logic                rec_q, rec_d;
   logic                seen_low_q, seen_low_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]     rec_len_q, rec_len_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [7:0]          rd_data_q, rd_data_d;

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [7:0]          wr_dat;
   logic                rise;
   logic signed [8:0]   diff;
   logic signed [8:0]   mag;
   logic                trig;

   logic [7:0]          mem [DEPTH];

   always_comb begin
      diff = $signed({1'b0, in_data}) - 9'sd128;
      mag  = (diff < 0) ? -diff : diff;
      trig = in_valid && (mag >= THR);
      // rec already high when reset releases must drop before it can start a take
      rise = rec && !rec_q && seen_low_q;

      state_d    = state_q;
      rec_d      = rec;
      seen_low_d = seen_low_q | ~rec;
      wr_ptr_d   = wr_ptr_q;
      rec_len_d  = rec_len_q;
      wr_en      = 1'b0;
      wr_addr    = wr_ptr_q;
      wr_dat     = in_data;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (rise) begin
               state_d   = START_ST;
               wr_ptr_d  = '0;
               rec_len_d = '0;
            end
         end
         ST_ARMED: begin
            if (!rec) begin
               state_d = ST_IDLE;
            end else if (trig) begin
               wr_en     = 1'b1;
               wr_addr   = '0;
               wr_ptr_d  = ADDR_W'(1);
               rec_len_d = (ADDR_W+1)'(1);
               state_d   = ST_REC;
            end
         end
         ST_REC: begin
            if (!rec) begin
               state_d = ST_DONE;
            end else if (in_valid) begin
               wr_en     = 1'b1;
               wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
               rec_len_d = rec_len_q + (ADDR_W+1)'(1);
               if (rec_len_q == LEN_LAST) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d    = (state_d == ST_ARMED) || (state_d == ST_REC);
      done_d    = (state_d == ST_DONE);
      rd_data_d = mem[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rec_q      <= 1'b0;
         seen_low_q <= 1'b0;
         wr_ptr_q   <= '0;
         rec_len_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rec_q      <= rec_d;
         seen_low_q <= seen_low_d;
         wr_ptr_q   <= wr_ptr_d;
         rec_len_q  <= rec_len_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // RAM has no reset; a same-address read in a write cycle sees the old word
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_data = rd_data_q;
   assign rec_len = rec_len_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sample_recorder.sv
// Randomized bench for sample_recorder: each take is predicted from the sample list as a whole
// (leading quiet samples dropped when triggering is built in, length capped at DEPTH).
module tb_sample_recorder;

   localparam int DEPTH     = 4096;
   localparam int ADDR_W    = 12;
   localparam int THRESHOLD = 16;
`ifdef THRESHOLD_TRIG_EN
   localparam bit TRIG_EN = 1'b1;
`else
   localparam bit TRIG_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              rec;
   logic              in_valid;
   logic [7:0]        in_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic [ADDR_W:0]   rec_len;
   logic              busy;
   logic              done;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ref_mem   [DEPTH];
   bit         ref_known [DEPTH];
   logic [7:0] stim_q[$];
   logic [7:0] kept_q[$];

   sample_recorder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .THRESHOLD(THRESHOLD)) dut (
      .clk(clk), .rst(rst), .rec(rec), .in_valid(in_valid), .in_data(in_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rec_len(rec_len), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit loud(input logic [7:0] s);
      int m;
      m = int'(s) - 128;
      if (m < 0) m = -m;
      return m >= THRESHOLD;
   endfunction

   task automatic read_chk(input int addr);
      rd_addr = ADDR_W'(addr);
      tick();
      if (ref_known[addr]) check($sformatf("rd[%0d]", addr), rd_data, ref_mem[addr]);
   endtask

   // Streams stim_q as one take; tail_valid presents a sample on the cycle rec drops.
   task automatic run_take(input bit gaps, input bit tail_valid);
      bit live;
      live   = !TRIG_EN;
      kept_q = {};
      rec = 1'b1;
      tick();
      check("busy_start", busy, 1);
      foreach (stim_q[i]) begin
         in_valid = 1'b1;
         in_data  = stim_q[i];
         tick();
         in_valid = 1'b0;
         if (!live && loud(stim_q[i])) live = 1'b1;
         if (live && kept_q.size() < DEPTH) begin
            kept_q.push_back(stim_q[i]);
            if (kept_q.size() == DEPTH) begin
               check("full_busy", busy, 0);
               check("full_done", done, 1);
               check("full_len", rec_len, DEPTH);
            end
         end
         if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
      rec = 1'b0;
      if (tail_valid) begin
         in_valid = 1'b1;
         in_data  = 8'h55;
      end
      tick();
      in_valid = 1'b0;
      check("end_done", done, live ? 1 : 0);
      check("end_busy", busy, 0);
      check("end_len", rec_len, kept_q.size());
      foreach (kept_q[i]) begin
         ref_mem[i]   = kept_q[i];
         ref_known[i] = 1'b1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; rec = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
      foreach (ref_known[i]) ref_known[i] = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_len", rec_len, 0);
      check("rst_rd", rd_data, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // basic 10-sample take and readback
      stim_q = {};
      for (int i = 1; i <= 10; i++) stim_q.push_back(8'(i));
      run_take(1'b0, 1'b0);
      for (int a = 0; a < 10; a++) read_chk(a);

      // fill to DEPTH with rec held; overflow samples differ from the first ones
      stim_q = {};
      for (int i = 0; i < DEPTH; i++) stim_q.push_back(8'($urandom_range(0, 255)));
      stim_q[0] = 8'h01;
      for (int k = 0; k < 5; k++) stim_q.push_back(~stim_q[k]);
      run_take(1'b0, 1'b0);
      read_chk(0); read_chk(1); read_chk(4); read_chk(DEPTH - 1);
      for (int k = 0; k < 10; k++) read_chk($urandom_range(0, DEPTH - 1));

      // rec held high after a full take does not restart
      stim_q = {};
      for (int i = 0; i < DEPTH + 2; i++) stim_q.push_back(8'h01 + 8'(i % 100));
      rec = 1'b1;
      tick();
      foreach (stim_q[i]) begin
         in_valid = 1'b1; in_data = stim_q[i]; tick();
      end
      in_valid = 1'b0;
      check("full_hold_done", done, 1);
      check("full_hold_len", rec_len, DEPTH);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 8'hEE; tick();
      end
      in_valid = 1'b0;
      check("hold_no_restart_busy", busy, 0);
      check("hold_no_restart_len", rec_len, DEPTH);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = stim_q[i];
      read_chk(0); read_chk(DEPTH - 1);
      rec = 1'b0;
      tick();

      // rec falls with a sample present: that sample is not written
      stim_q = {8'h31, 8'h32, 8'h33};
      run_take(1'b0, 1'b1);
      for (int a = 0; a < 4; a++) read_chk(a);

      // trigger sequences (plain captures when triggering is not built in)
      stim_q = {8'h80, 8'h85, 8'h8F, 8'h90, 8'h20};
      run_take(1'b0, 1'b0);
      for (int a = 0; a < 5; a++) read_chk(a);
      stim_q = {8'h81, 8'h7F, 8'h70, 8'h33};
      run_take(1'b1, 1'b0);
      for (int a = 0; a < 4; a++) read_chk(a);
      stim_q = {8'h8F, 8'h00};
      run_take(1'b0, 1'b0);
      read_chk(0); read_chk(1);

      // reset mid-take
      rec = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = 8'h01 + 8'(i); tick();
         ref_mem[i] = 8'h01 + 8'(i);
      end
      in_valid = 1'b0;
      check("pre_rst_len", rec_len, 7);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_len", rec_len, 0);
      tick(); tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 8'h7A + 8'(k); tick();
      end
      in_valid = 1'b0;
      check("post_rst_busy", busy, 0);
      check("post_rst_len", rec_len, 0);
      for (int a = 0; a < 8; a++) read_chk(a);
      rec = 1'b0; tick();
      rec = 1'b1; tick();
      check("rearm_busy", busy, 1);
      rec = 1'b0; tick();
      check("empty_done", done, TRIG_EN ? 0 : 1);
      check("empty_len", rec_len, 0);

      // read/write collision on address 5
      stim_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h11};
      run_take(1'b0, 1'b0);
      rec = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'h20 + 8'(i); tick();
         ref_mem[i] = 8'h20 + 8'(i);
      end
      rd_addr = ADDR_W'(5);
      in_valid = 1'b1; in_data = 8'hAA;
      tick();
      in_valid = 1'b0;
      check("coll_old", rd_data, 8'h11);
      tick();
      check("coll_new", rd_data, 8'hAA);
      ref_mem[5] = 8'hAA;
      rec = 1'b0;
      tick();
      check("coll_len", rec_len, 6);

      // randomized takes
      for (int t = 0; t < 10; t++) begin
         n = $urandom_range(1, 40);
         stim_q = {};
         for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 3)) tick();
         run_take(1'b1, $urandom_range(0, 1) == 1);
         for (int a = 0; a < n + 2; a++) read_chk(a);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
